vram_word_fetcher: RTL and testbench

Sequential word fetcher on the read port of the vector-RAM dual-port memory. It drives the byte address, captures the registered read data (one-cycle latency), and assembles little-endian byte pairs into 2×DATA_WIDTH-bit vector instruction words. Words are buffered in a small FIFO and handed to the vector generator state machine over a valid/ready handshake. The block supports start, redirect (jump) and halt from the consumer.

---
 rtl/vram_word_fetcher.sv | 150 +++++++++++++++
 tb/tb_vram_word_fetcher.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vram_word_fetcher.sv
// Sequential word fetcher for the vector-RAM read port: issues byte addresses, pairs
// little-endian bytes into words and queues them in a small FIFO for the consumer.
module vram_word_fetcher #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic                    jump,
  input  logic [ADDR_WIDTH-1:0]   jump_addr,
  input  logic                    halt,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0]   ram_q,
  output logic [2*DATA_WIDTH-1:0] word_out,
  output logic [ADDR_WIDTH-1:0]   word_addr,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy
);

  localparam int unsigned PW = ADDR_WIDTH - 1;
  localparam int unsigned WW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = ADDR_WIDTH + WW;

  typedef enum logic {IDLE, RUN}    state_t;
  typedef enum logic {PH_LO, PH_HI} phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [PW-1:0]         ptr_q, ptr_d, cmd_ptr;
  logic [ADDR_WIDTH-1:0] addr_d;

  logic                  iss_v, iss_hi;
  logic [PW-1:0]         iss_ptr;
  logic                  s1_v, s1_hi, s2_v, s2_hi;
  logic [PW-1:0]         s1_ptr, s2_ptr;
  logic [DATA_WIDTH-1:0] lo_q;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [CW-1:0]         wr_q, rd_q;
  logic [CW:0]           cnt_q;
  logic [CW+1:0]         occupancy;
  logic                  flush, push, pop, inflight;

  assign pop      = word_valid && word_ready;
  assign push     = s2_v && s2_hi && !flush;
  assign inflight = s1_v || s2_v || (phase_q == PH_HI);
  assign occupancy = (CW+2)'(cnt_q) + (CW+2)'(inflight);
  assign cmd_ptr  = jump ? jump_addr[ADDR_WIDTH-1:1] : start_addr[ADDR_WIDTH-1:1];

  // A command issues the LO byte of its first word on the same edge, so the
  // registered phase records the half still owed (HI) rather than LO.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
    addr_d  = ram_addr;
    iss_v   = 1'b0;
    iss_hi  = 1'b0;
    iss_ptr = ptr_q;
    flush   = 1'b0;
    if (halt) begin
      state_d = IDLE;
      phase_d = PH_LO;
      flush   = 1'b1;
    end else if (jump || start) begin
      state_d = RUN;
      ptr_d   = cmd_ptr;
      addr_d  = {cmd_ptr, 1'b0};
      iss_v   = 1'b1;
      iss_ptr = cmd_ptr;
      phase_d = PH_HI;
      flush   = 1'b1;
    end else if (state_q == RUN) begin
      if (phase_q == PH_HI) begin
        addr_d  = {ptr_q, 1'b1};
        ptr_d   = ptr_q + PW'(1);
        iss_v   = 1'b1;
        iss_hi  = 1'b1;
        phase_d = PH_LO;
      end else if (occupancy < (CW+2)'(FIFO_DEPTH)) begin
        addr_d  = {ptr_q, 1'b0};
        iss_v   = 1'b1;
        phase_d = PH_HI;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= PH_LO;
      ptr_q    <= '0;
      ram_addr <= '0;
      s1_v     <= 1'b0;
      s1_hi    <= 1'b0;
      s1_ptr   <= '0;
      s2_v     <= 1'b0;
      s2_hi    <= 1'b0;
      s2_ptr   <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ptr_q    <= ptr_d;
      ram_addr <= addr_d;
      s1_v     <= iss_v;
      s1_hi    <= iss_hi;
      s1_ptr   <= iss_ptr;
      s2_v     <= s1_v && !flush;
      s2_hi    <= s1_hi;
      s2_ptr   <= s1_ptr;
      if (s2_v && !s2_hi && !flush) lo_q <= ram_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= {s2_ptr, 1'b0, ram_q, lo_q};
        wr_q      <= wr_q + CW'(1);
      end
      if (pop) rd_q <= rd_q + CW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (CW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (CW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign word_out   = mem[rd_q][WW-1:0];
  assign word_addr  = mem[rd_q][EW-1:WW];
  assign word_valid = (cnt_q != '0);
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_vram_word_fetcher.sv
// Bench for vram_word_fetcher: directed scenarios plus randomized commands and back-pressure
// checked against a stream model (word k after a command comes from word index addr/2 + k).
module tb_vram_word_fetcher;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start, jump, halt, word_ready;
  logic [AW-1:0] start_addr, jump_addr, ram_addr, word_addr;
  logic [DW-1:0] ram_q;
  logic [15:0]   word_out;
  logic          word_valid, busy;

  logic [7:0]    ram [0:32767];
  int            checks = 0;
  int            errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) ram_q <= ram[ram_addr];

  vram_word_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .jump(jump), .jump_addr(jump_addr), .halt(halt), .ram_addr(ram_addr),
    .ram_q(ram_q), .word_out(word_out), .word_addr(word_addr),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [AW-1:0] a);
    logic [AW-1:0] lo_a, hi_a;
    lo_a = {a[AW-1:1], 1'b0};
    hi_a = {a[AW-1:1], 1'b1};
    return {ram[hi_a], ram[lo_a]};
  endfunction

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!word_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, word_valid, 1);
  endtask

  task automatic issue_start(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a;
    @(negedge clock);
    start = 1'b0;
  endtask

  logic [AW-1:0] a0;
  logic [AW-2:0] exp_p;
  bit            active;
  int            n;

  initial begin
    reset_n = 1'b0; start = 0; jump = 0; halt = 0; word_ready = 0;
    start_addr = '0; jump_addr = '0;
    for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) ram[16'h100 + i] = 8'(8'h11 * (i + 1));

    repeat (3) @(negedge clock);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_valid", word_valid, 0);
    check("rst_word_out", word_out, 0);
    check("rst_word_addr", word_addr, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // basic stream with latency and cadence
    word_ready = 1'b1;
    issue_start(15'h0100);
    wait_valid("t1_w0", n);
    check("t1_latency", n, 3);
    check("t1_w0_data", word_out, 16'h2211);
    check("t1_w0_addr", word_addr, 15'h0100);
    @(negedge clock);
    wait_valid("t1_w1", n);
    check("t1_w1_gap", n, 1);
    check("t1_w1_data", word_out, 16'h4433);
    check("t1_w1_addr", word_addr, 15'h0102);
    @(negedge clock);
    wait_valid("t1_w2", n);
    check("t1_w2_gap", n, 1);
    check("t1_w2_data", word_out, 16'h6655);
    check("t1_w2_addr", word_addr, 15'h0104);

    // back-pressure: exactly four words, address frozen, then in-order drain
    word_ready = 1'b0;
    issue_start(15'h0300);
    repeat (20) @(negedge clock);
    check("t2_frozen_addr", ram_addr, 15'h0307);
    repeat (5) @(negedge clock);
    check("t2_still_frozen", ram_addr, 15'h0307);
    check("t2_valid", word_valid, 1);
    word_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid("t2_drain", n);
      check("t2_addr", word_addr, 15'(15'h0300 + 2 * k));
      check("t2_data", word_out, exp_word(15'(15'h0300 + 2 * k)));
      @(negedge clock);
    end

    // jump with queued words and a half-fetched word
    word_ready = 1'b0;
    issue_start(15'h0400);
    repeat (6) @(negedge clock);
    jump = 1'b1; jump_addr = 15'h0200;
    @(negedge clock);
    jump = 1'b0;
    check("t3_flushed", word_valid, 0);
    word_ready = 1'b1;
    wait_valid("t3_w0", n);
    check("t3_latency", n, 3);
    check("t3_addr", word_addr, 15'h0200);
    check("t3_data", word_out, exp_word(15'h0200));

    // wrap at top of address space
    issue_start(15'h7FFE);
    wait_valid("t4_w0", n);
    check("t4_w0_addr", word_addr, 15'h7FFE);
    check("t4_w0_data", word_out, exp_word(15'h7FFE));
    @(negedge clock);
    wait_valid("t4_w1", n);
    check("t4_w1_addr", word_addr, 15'h0000);
    check("t4_w1_data", word_out, exp_word(15'h0000));

    // halt beats jump in the same cycle
    issue_start(15'h0500);
    repeat (5) @(negedge clock);
    a0 = ram_addr;
    halt = 1'b1; jump = 1'b1; jump_addr = 15'h0600;
    @(negedge clock);
    halt = 1'b0; jump = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", word_valid, 0);
    check("t5_addr_hold", ram_addr, a0);
    repeat (5) @(negedge clock);
    check("t5_addr_still", ram_addr, a0);
    check("t5_valid_still", word_valid, 0);

    // asynchronous reset mid-fetch
    issue_start(15'h0700);
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t6_ram_addr", ram_addr, 0);
    check("t6_valid", word_valid, 0);
    check("t6_word_out", word_out, 0);
    check("t6_word_addr", word_addr, 0);
    check("t6_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("t6_no_fetch_addr", ram_addr, 0);
    check("t6_no_fetch_valid", word_valid, 0);

    // randomized commands and back-pressure against the stream model
    active = 0;
    exp_p  = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      check("rnd_busy", busy, 32'(active));
      if (!active) check("rnd_idle_valid", word_valid, 0);
      n = $urandom_range(0, 99);
      halt       = (n < 2);
      jump       = (n >= 2 && n < 6);
      start      = (n >= 6 && n < 8);
      jump_addr  = 15'($urandom_range(0, 32767));
      start_addr = 15'($urandom_range(0, 32767));
      word_ready = ($urandom_range(0, 3) != 0);
      if (word_valid && word_ready) begin
        check("rnd_addr", word_addr, {exp_p, 1'b0});
        check("rnd_data", word_out, exp_word({exp_p, 1'b0}));
        exp_p = exp_p + 1'b1;
      end
      if (halt) active = 0;
      else if (jump) begin active = 1; exp_p = jump_addr[AW-1:1]; end
      else if (start) begin active = 1; exp_p = start_addr[AW-1:1]; end
      @(negedge clock);
    end
    halt = 0; jump = 0; start = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
